video_stream_fifo_adapter: RTL and testbench

- Parametrised successor to the single-register video sink adapter.
- Sits between an Avalon-ST video source (e.g. frame reader or clocked-video input) and the processing pipeline.
- Buffers up to DEPTH beats with full ready/valid backpressure.
- Enforces packet framing: drops stray beats outside packets and flags malformed packets.

---
 rtl/video_stream_fifo_adapter.sv | 115 +++++++++++
 tb/tb_video_stream_fifo_adapter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_fifo_adapter.sv
// Avalon-ST video sink adapter: DEPTH-beat ready/valid FIFO with packet framing enforcement.
// Define VIDEO_STREAM_FIFO_DROP_CNT_EN to add a saturating dropped-beat counter (drop_cnt, drop_cnt_clr).
module video_stream_fifo_adapter #(
    parameter int DATA_W  = 24,
    parameter int EMPTY_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       snk_valid,
    input  logic                       snk_sop,
    input  logic                       snk_eop,
    input  logic [DATA_W-1:0]          snk_data,
    input  logic [EMPTY_W-1:0]         snk_empty,
    output logic                       snk_ready,
    input  logic                       src_ready,
    output logic                       src_valid,
    output logic                       src_sop,
    output logic                       src_eop,
    output logic [DATA_W-1:0]          src_data,
    output logic [EMPTY_W-1:0]         src_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       frame_err
`ifdef VIDEO_STREAM_FIFO_DROP_CNT_EN
    ,
    input  logic                       drop_cnt_clr,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int WW = DATA_W + EMPTY_W + 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("video_stream_fifo_adapter: DEPTH must be a power of two and >= 2");
    end

    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [0:0]    state;
    logic          snk_acc;
    logic          rd_en;
    logic          wr_en;
    logic          drop;
    logic          err;
    logic [WW-1:0] rd_word;

    assign snk_ready = (level != LW'(DEPTH));
    assign src_valid = (level != '0);
    assign snk_acc   = snk_valid & snk_ready;
    assign rd_en     = src_valid & src_ready;

    // A beat outside a packet without sop is swallowed; a sop inside a packet restarts framing.
    assign drop  = snk_acc & (state == ST_IDLE) & ~snk_sop;
    assign wr_en = snk_acc & ~drop;
    assign err   = drop | (snk_acc & (state == ST_PKT) & snk_sop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {snk_sop, snk_eop, snk_empty, snk_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= ST_IDLE;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                state  <= snk_eop ? ST_IDLE : ST_PKT;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_word   = mem[rd_ptr];
    assign src_data  = src_valid ? rd_word[DATA_W-1:0] : '0;
    assign src_empty = src_valid ? rd_word[DATA_W +: EMPTY_W] : '0;
    assign src_eop   = src_valid & rd_word[WW-2];
    assign src_sop   = src_valid & rd_word[WW-1];

`ifdef VIDEO_STREAM_FIFO_DROP_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_cnt_clr) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_video_stream_fifo_adapter.sv
// Directed bench for video_stream_fifo_adapter (DEPTH=4): latency, backpressure, framing, wrap, reset.
module tb_video_stream_fifo_adapter;

    localparam int DATA_W  = 24;
    localparam int EMPTY_W = 2;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               snk_valid, snk_sop, snk_eop;
    logic [DATA_W-1:0]  snk_data;
    logic [EMPTY_W-1:0] snk_empty;
    logic               snk_ready;
    logic               src_ready;
    logic               src_valid, src_sop, src_eop;
    logic [DATA_W-1:0]  src_data;
    logic [EMPTY_W-1:0] src_empty;
    logic [2:0]         level;
    logic               frame_err;
`ifdef VIDEO_STREAM_FIFO_DROP_CNT_EN
    logic               drop_cnt_clr;
    logic [15:0]        drop_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    video_stream_fifo_adapter #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_data(snk_data), .snk_empty(snk_empty), .snk_ready(snk_ready),
        .src_ready(src_ready), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_data(src_data), .src_empty(src_empty), .level(level), .frame_err(frame_err)
`ifdef VIDEO_STREAM_FIFO_DROP_CNT_EN
        , .drop_cnt_clr(drop_cnt_clr), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sop, input logic eop, input logic [DATA_W-1:0] d);
        snk_valid = v;
        snk_sop   = sop;
        snk_eop   = eop;
        snk_data  = d;
        snk_empty = d[EMPTY_W-1:0];
    endtask

    // {valid, sop, eop, level, data} bundled so one check covers the whole output beat.
    function automatic logic [31:0] beat(input logic v, input logic s, input logic e,
                                         input logic [2:0] l, input logic [23:0] d);
        return {2'b0, v, s, e, l, d};
    endfunction

    function automatic logic [31:0] obs_beat();
        return {2'b0, src_valid, src_sop, src_eop, level, src_data};
    endfunction

    int sent, rcvd, cyc;

    initial begin
        rst = 1'b1;
        src_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
`ifdef VIDEO_STREAM_FIFO_DROP_CNT_EN
        drop_cnt_clr = 1'b0;
`endif
        tick();
        tick();
        check("reset_beat", obs_beat(), beat(0, 0, 0, 0, 24'h0));
        check("reset_err", {31'b0, frame_err}, 32'd0);
        check("reset_empty", {30'b0, src_empty}, 32'd0);
        rst = 1'b0;

        // 3-beat packet, free-flowing output
        src_ready = 1'b1;
        drive(1, 1, 0, 24'h000001);
        tick();
        check("pkt_b1", obs_beat(), beat(1, 1, 0, 1, 24'h000001));
        check("pkt_b1_empty", {30'b0, src_empty}, 32'd1);
        drive(1, 0, 0, 24'h000002);
        tick();
        check("pkt_b2", obs_beat(), beat(1, 0, 0, 1, 24'h000002));
        drive(1, 0, 1, 24'h000003);
        tick();
        check("pkt_b3", obs_beat(), beat(1, 0, 1, 1, 24'h000003));
        drive(0, 0, 0, 24'h0);
        tick();
        check("pkt_idle", obs_beat(), beat(0, 0, 0, 0, 24'h0));
        check("pkt_noerr", {31'b0, frame_err}, 32'd0);

        // fill to DEPTH with output stalled, then drain
        src_ready = 1'b0;
        drive(1, 1, 0, 24'h000010);
        tick();
        check("fill_l1", {29'b0, level}, 32'd1);
        drive(1, 0, 0, 24'h000011);
        tick();
        drive(1, 0, 0, 24'h000012);
        tick();
        check("fill_rdy3", {31'b0, snk_ready}, 32'd1);
        drive(1, 0, 0, 24'h000013);
        tick();
        check("full_level", {29'b0, level}, 32'd4);
        check("full_rdy", {31'b0, snk_ready}, 32'd0);
        drive(1, 0, 1, 24'h000014);
        tick();
        check("full_hold", obs_beat(), beat(1, 1, 0, 4, 24'h000010));
        check("full_rdy2", {31'b0, snk_ready}, 32'd0);
        src_ready = 1'b1;
        tick();
        check("drain1", obs_beat(), beat(1, 0, 0, 3, 24'h000011));
        check("drain1_rdy", {31'b0, snk_ready}, 32'd1);
        tick();
        check("drain2", obs_beat(), beat(1, 0, 0, 3, 24'h000012));
        drive(0, 0, 0, 24'h0);
        tick();
        check("drain3", obs_beat(), beat(1, 0, 0, 2, 24'h000013));
        tick();
        check("drain4", obs_beat(), beat(1, 0, 1, 1, 24'h000014));
        tick();
        check("drain_done", obs_beat(), beat(0, 0, 0, 0, 24'h0));

        // stray beats outside a packet
        drive(1, 0, 0, 24'hAAAAAA);
        tick();
        check("stray1_err", {31'b0, frame_err}, 32'd1);
        check("stray1_beat", obs_beat(), beat(0, 0, 0, 0, 24'h0));
        drive(1, 0, 0, 24'hBBBBBB);
        tick();
        check("stray2_err", {31'b0, frame_err}, 32'd1);
        check("stray2_beat", obs_beat(), beat(0, 0, 0, 0, 24'h0));
        drive(1, 1, 1, 24'hCCCCCC);
        tick();
        check("stray_sop_err", {31'b0, frame_err}, 32'd0);
        check("stray_sop_beat", obs_beat(), beat(1, 1, 1, 1, 24'hCCCCCC));
        drive(0, 0, 0, 24'h0);
        tick();
        check("stray_idle", obs_beat(), beat(0, 0, 0, 0, 24'h0));
`ifdef VIDEO_STREAM_FIFO_DROP_CNT_EN
        check("drop_cnt", {16'b0, drop_cnt}, 32'd2);
        drop_cnt_clr = 1'b1;
        tick();
        drop_cnt_clr = 1'b0;
        check("drop_clr", {16'b0, drop_cnt}, 32'd0);
`endif

        // packet missing eop followed by a new sop
        drive(1, 1, 0, 24'h000021);
        tick();
        check("noeop_b1", obs_beat(), beat(1, 1, 0, 1, 24'h000021));
        drive(1, 0, 0, 24'h000022);
        tick();
        check("noeop_b2", obs_beat(), beat(1, 0, 0, 1, 24'h000022));
        check("noeop_b2_err", {31'b0, frame_err}, 32'd0);
        drive(1, 1, 0, 24'h000031);
        tick();
        check("resop_err", {31'b0, frame_err}, 32'd1);
        check("resop_beat", obs_beat(), beat(1, 1, 0, 1, 24'h000031));
        drive(1, 0, 1, 24'h000032);
        tick();
        check("resop_eop_err", {31'b0, frame_err}, 32'd0);
        check("resop_eop", obs_beat(), beat(1, 0, 1, 1, 24'h000032));
        drive(0, 0, 0, 24'h0);
        tick();
        check("resop_idle", obs_beat(), beat(0, 0, 0, 0, 24'h0));

        // 64-beat stream with toggling src_ready
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 64 && cyc < 1000) begin
            drive(sent < 64, sent == 0, sent == 63, 24'h000100 + 24'(sent));
            src_ready = (cyc % 2) == 0;
            if (src_valid && src_ready) begin
                check("stream_beat", {5'b0, src_sop, src_eop, 1'b0, src_data},
                      {5'b0, rcvd == 0, rcvd == 63, 1'b0, 24'h000100 + 24'(rcvd)});
                rcvd++;
            end
            if (snk_valid && snk_ready) sent++;
            tick();
            cyc++;
        end
        check("stream_count", 32'(rcvd), 32'd64);
        drive(0, 0, 0, 24'h0);
        src_ready = 1'b1;
        tick();
        check("stream_empty", obs_beat(), beat(0, 0, 0, 0, 24'h0));

        // reset mid-packet
        src_ready = 1'b0;
        drive(1, 1, 0, 24'h000041);
        tick();
        drive(1, 0, 0, 24'h000042);
        tick();
        drive(1, 0, 0, 24'h000043);
        tick();
        check("mid_level", {29'b0, level}, 32'd3);
        drive(0, 0, 0, 24'h0);
        rst = 1'b1;
        #1;
        check("async_rst", obs_beat(), beat(0, 0, 0, 0, 24'h0));
        tick();
        rst = 1'b0;
        src_ready = 1'b1;
        drive(1, 0, 0, 24'h000050);
        tick();
        check("post_rst_err", {31'b0, frame_err}, 32'd1);
        check("post_rst_beat", obs_beat(), beat(0, 0, 0, 0, 24'h0));
        drive(0, 0, 0, 24'h0);
        tick();
        check("post_rst_err_off", {31'b0, frame_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
